// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one int_multiplier between
// two level-held requesters. Latches the granted operands, pulses the
// multiplier start, waits out its WIDTH-cycle latency, then returns the
// product with a one-cycle ack to the granted requester.
module mult_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_id,
    output logic                 busy,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic                 mul_start,
    input  logic [2*WIDTH-1:0]   mul_product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic                 gid_q, gid_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 result_id_q, result_id_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;

    logic                 elig0, elig1, gsel;

    // A requester whose ack is high this cycle is still dropping req; mask it.
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;

    // Next-state, grant and datapath capture logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gid_d       = gid_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        gsel        = 1'b0;
        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    // Tie goes to the requester not served last.
                    gsel    = (elig0 & elig1) ? ~last_q : elig1;
                    state_d = START;
                    gid_d   = gsel;
                    last_d  = gsel;
                    mul_a_d = gsel ? a1 : a0;
                    mul_b_d = gsel ? b1 : b0;
                end
            end
            START: begin
                state_d = BUSY;
                cnt_d   = '0;
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CW'(WIDTH)) state_d = DONE;
            end
            DONE: begin
                result_d    = mul_product;
                result_id_d = gid_q;
                ack0_d      = ~gid_q;
                ack1_d      = gid_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            gid_q       <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            result_q    <= '0;
            result_id_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gid_q       <= gid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign result    = result_q;
    assign result_id = result_id_q;
    assign busy      = (state_q != IDLE);
    assign mul_start = (state_q == START);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter with a behavioural WIDTH-cycle multiplier model.
module tb_mult_arbiter;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           ack0, ack1;
    logic [2*W-1:0] result;
    logic           result_id;
    logic           busy;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_start;
    logic [2*W-1:0] mul_product;

    always #5 clk = ~clk;

    mult_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .result(result), .result_id(result_id), .busy(busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_product(mul_product)
    );

    // Multiplier model: samples operands on start, product valid W cycles
    // later; garbage before that so a premature DONE is visible.
    logic [W-1:0] mp_a = '0, mp_b = '0;
    logic [2:0]   mp_k = 3'd4;
    always @(posedge clk) begin
        if (mul_start) begin
            mp_a <= mul_a;
            mp_b <= mul_b;
            mp_k <= 3'd0;
        end else if (mp_k != 3'(W)) begin
            mp_k <= mp_k + 3'd1;
        end
    end
    assign mul_product = (mp_k == 3'(W)) ? ({4'b0, mp_a} * {4'b0, mp_b}) : 8'hA5;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic           id;
        logic [2*W-1:0] res;
        int             at;
    } exp_t;
    exp_t sb[$];

    task automatic push(input logic id, input logic [2*W-1:0] res, input int dly);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.at  = cyc + dly;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ack0"}, ack0, 0);
        chk({p, "_ack1"}, ack1, 0);
        chk({p, "_result"}, result, 0);
        chk({p, "_rid"}, result_id, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_mul_a"}, mul_a, 0);
        chk({p, "_mul_b"}, mul_b, 0);
        chk({p, "_start"}, mul_start, 0);
    endtask

    // Scoreboard: every ack must match the oldest expected completion.
    always @(negedge clk) begin
        if (ack0 | ack1) begin
            chk("ack_excl", ack0 & ack1, 0);
            if (sb.size() == 0) begin
                chk("spurious_ack", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_id", ack1, e.id);
                chk("result", result, e.res);
                chk("result_id", result_id, e.id);
                chk("ack_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step(2);
        chk_zero("rst");
        reset = 1'b0;
        step(1);

        // Single request 5x3: start in cycle 1, busy 1..6, ack in 7.
        a0 = 4'd5; b0 = 4'd3; req0 = 1'b1;
        push(1'b0, 8'd15, 7);
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk("t1_busy", busy, (k <= 6));
            chk("t1_start", mul_start, (k == 1));
            if (k == 3) begin
                chk("t1_mul_a", mul_a, 5);
                chk("t1_mul_b", mul_b, 3);
            end
        end
        req0 = 1'b0;
        step(2);

        // Simultaneous requests after reset: 0 first, 1 granted in ack cycle.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        a0 = 4'd15; b0 = 4'd15; a1 = 4'd0; b1 = 4'd3;
        req0 = 1'b1; req1 = 1'b1;
        push(1'b0, 8'd225, 7);
        push(1'b1, 8'd0, 14);
        step(7);
        req0 = 1'b0;
        step(7);
        req1 = 1'b0;
        step(2);

        // Both held for four operations: alternation 0,1,0,1.
        a0 = 4'd2; b0 = 4'd3; a1 = 4'd4; b1 = 4'd5;
        req0 = 1'b1; req1 = 1'b1;
        push(1'b0, 8'd6, 7);
        push(1'b1, 8'd20, 14);
        push(1'b0, 8'd42, 21);
        push(1'b1, 8'd81, 28);
        step(7);
        a0 = 4'd6; b0 = 4'd7;
        step(7);
        a1 = 4'd9; b1 = 4'd9;
        step(7);
        req0 = 1'b0;
        step(7);
        req1 = 1'b0;
        step(2);

        // Operands latched at grant: change during BUSY is ignored.
        a1 = 4'd5; b1 = 4'd0; req1 = 1'b1;
        push(1'b1, 8'd0, 7);
        step(3);
        a1 = 4'd7; b1 = 4'd7;
        step(1);
        chk("t4_mul_a", mul_a, 5);
        chk("t4_mul_b", mul_b, 0);
        step(3);
        req1 = 1'b0;
        step(2);

        // Reset during BUSY abandons the op; next op works normally.
        a0 = 4'd5; b0 = 4'd3; req0 = 1'b1;
        step(3);
        reset = 1'b1; req0 = 1'b0;
        step(1);
        chk_zero("t5");
        reset = 1'b0;
        step(2);
        a0 = 4'd3; b0 = 4'd3; req0 = 1'b1;
        push(1'b0, 8'd9, 7);
        step(7);
        req0 = 1'b0;
        step(2);

        // req held through its own ack cycle must not be re-granted.
        a0 = 4'd2; b0 = 4'd2; req0 = 1'b1;
        push(1'b0, 8'd4, 7);
        step(8);
        chk("t6_busy", busy, 0);
        chk("t6_start", mul_start, 0);
        req0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("t6_idle_busy", busy, 0);
            chk("t6_idle_start", mul_start, 0);
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
        chk("sb_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
